dash_alert_sched: RTL and testbench
===================================

Name: dash_alert_sched

Overview:
Dashboard alert scheduler that shares the single cabin buzzer between the door-open and seatbelt-unfastened alert sources. Qualifies raw door and belt states with ignition and vehicle motion, and runs a belt grace period and maximum alert duration. Handles a driver mute button and applies priority: a door open while moving preempts belt alerts. Sits between the debounced switch inputs and the indicator/buzzer drivers of the instrument panel.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
TICK_HZ, 4, internal timebase tick rate in Hz; all timing is counted in ticks.
BELT_GRACE_S, 5, seconds a belt may stay unfastened with ignition on before the alert starts.
ALERT_MAX_S, 60, seconds a belt alert may sound before auto-mute.
N_DOORS, 4, number of door switches.
N_BELTS, 2, number of belt switches.

Ports:
clock  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
ignition  in  1  ignition on; synchronous to clock.
moving  in  1  vehicle speed nonzero; synchronous.
door_open  in  N_DOORS  1 = door open; debounced and synchronous.
belt_open  in  N_BELTS  1 = belt unfastened; debounced and synchronous.
ack  in  1  mute button, single-cycle pulse.
buzzer  out  1  buzzer drive, registered.
door_led  out  N_DOORS  door indicators, registered.
belt_led  out  N_BELTS  belt indicators, registered.
alert_class  out  2  0 none, 1 belt, 2 door; registered.

Behaviour:
- Reset (async assert, synchronous release): state IDLE; all counters 0; buzzer, door_led, belt_led, alert_class all 0.
- All inputs are registered once (stage R). Definitions on R: DOOR_C = ignition & moving & |door_open; BELT_C = ignition & |belt_open; BELT_NEW = any belt_open bit rising (0->1).
- tick: one-cycle pulse every CLK_HZ/TICK_HZ clocks, from a free-running prescaler. The prescaler wraps to 0 at CLK_HZ/TICK_HZ-1.
- Beep phase register: forced to 1 on entry to DOOR_ALERT or BELT_ALERT.
  - DOOR_ALERT: phase toggles every tick (2 Hz at TICK_HZ=4).
  - BELT_ALERT: phase toggles every second tick (1 Hz).
- States and transitions (evaluated in priority order each cycle):
  - IDLE: DOOR_C -> DOOR_ALERT; else BELT_C -> BELT_GRACE, grace counter = BELT_GRACE_S*TICK_HZ.
  - BELT_GRACE: DOOR_C -> DOOR_ALERT; !BELT_C -> IDLE; counter decrements on tick; tick at counter==1 -> BELT_ALERT with duration counter = ALERT_MAX_S*TICK_HZ. ack ignored.
  - BELT_ALERT: DOOR_C -> DOOR_ALERT; !BELT_C -> IDLE; ack -> MUTED; duration decrements on tick; tick at counter==1 -> MUTED.
  - DOOR_ALERT: ack ignored (door alert is not mutable); !DOOR_C -> IDLE, which re-evaluates next cycle. Belt grace restarts from full.
  - MUTED: DOOR_C -> DOOR_ALERT; !BELT_C -> IDLE; BELT_NEW -> BELT_ALERT with a fresh duration.
- Simultaneous events:
  - Door condition beats ack, expiry and belt events.
  - Condition clear beats ack and expiry.
  - ack and expiry in the same cycle -> MUTED.
- Outputs (registered, computed from next-state):
  - buzzer = phase in DOOR_ALERT and BELT_ALERT, else 0.
  - alert_class = 2 in DOOR_ALERT, 1 in BELT_ALERT, else 0.
  - door_led = door_open_R, but in DOOR_ALERT the set bits blink with phase.
  - belt_led = belt_open_R & {ignition_R}, steady in every state, including MUTED.
- Latency: a qualifying input change sampled at edge N (into R) drives buzzer/alert_class at edge N+1. Condition clear: buzzer 0 at edge N+1.
- Ignition drop in any state: IDLE within 1 cycle of R update; all counters discarded.
- Reset mid-alert: buzzer drops immediately (async).

Decomposition:
- Package dash_pkg:
  - state enum: IDLE, BELT_GRACE, BELT_ALERT, DOOR_ALERT, MUTED.
  - alert_class codes ALERT_NONE/BELT/DOOR.
  - Derived constants TICK_DIV = CLK_HZ/TICK_HZ, GRACE_TICKS, MAX_TICKS.
  - Counter widths via $clog2.
- One sub-module: dash_tick_gen (prescaler; ports clock, reset_n, tick).

Test Plan:
(Bench parameters: CLK_HZ=16, TICK_HZ=4 -> tick every 4 clocks; BELT_GRACE_S=2 -> 8 ticks; ALERT_MAX_S=3 -> 12 ticks.)
1. ignition=1, belt_open=01 held -> alert_class 0 for 8 ticks. Then alert_class=1, buzzer high for 2 ticks, low for 2 ticks, repeating. After 12 ticks: buzzer 0, belt_led=01 still lit.
2. In BELT_ALERT, pulse ack -> buzzer 0 next cycle (MUTED). Raise belt_open[1] -> BELT_ALERT with a fresh 12-tick duration, buzzer 1 next cycle.
3. ignition=1, moving=1, door_open=0100 -> alert_class=2 one cycle after R. Buzzer toggles every tick. door_led[2] blinks with buzzer. ack pulse has no effect.
4. Belt alert active, then door_open=0001 with moving=1 -> alert_class=2. On door close -> IDLE, then BELT_GRACE, with a full 8-tick grace before the belt buzzer resumes.
5. Drop ignition during DOOR_ALERT -> buzzer 0, alert_class 0, belt_led 0. Assert reset_n=0 mid-alert -> all outputs 0 immediately; after release, state IDLE.
6. ack and duration expiry in the same cycle -> MUTED. belt_open clear and expiry in the same cycle -> IDLE, with buzzer 0 in both cases.

Source files
------------

// File: rtl/dash_pkg.sv
// Shared types, default timing constants and sizing helpers for the
// dashboard alert scheduler.
package dash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BELT_GRACE,
    BELT_ALERT,
    DOOR_ALERT,
    MUTED
  } state_e;

  typedef enum logic [1:0] {
    ALERT_NONE = 2'd0,
    ALERT_BELT = 2'd1,
    ALERT_DOOR = 2'd2
  } alert_class_e;

  localparam int unsigned DEF_CLK_HZ       = 50_000_000;
  localparam int unsigned DEF_TICK_HZ      = 4;
  localparam int unsigned DEF_BELT_GRACE_S = 5;
  localparam int unsigned DEF_ALERT_MAX_S  = 60;
  localparam int unsigned DEF_N_DOORS      = 4;
  localparam int unsigned DEF_N_BELTS      = 2;
  localparam int unsigned DEF_TICK_DIV     = DEF_CLK_HZ / DEF_TICK_HZ;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dash_tick_gen.sv
// Free-running prescaler producing a one-clock tick every DIV clocks.
module dash_tick_gen import dash_pkg::*; #(
  parameter int unsigned DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_width(DIV - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    tick_d = (cnt_q == LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/dash_alert_sched.sv
// Shares the cabin buzzer between door-open and belt-unfastened alerts,
// with belt grace period, alert time-out, driver mute and door priority.
module dash_alert_sched import dash_pkg::*; #(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ      = DEF_TICK_HZ,
  parameter int unsigned BELT_GRACE_S = DEF_BELT_GRACE_S,
  parameter int unsigned ALERT_MAX_S  = DEF_ALERT_MAX_S,
  parameter int unsigned N_DOORS      = DEF_N_DOORS,
  parameter int unsigned N_BELTS      = DEF_N_BELTS
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ignition,
  input  logic               moving,
  input  logic [N_DOORS-1:0] door_open,
  input  logic [N_BELTS-1:0] belt_open,
  input  logic               ack,
  output logic               buzzer,
  output logic [N_DOORS-1:0] door_led,
  output logic [N_BELTS-1:0] belt_led,
  output logic [1:0]         alert_class
);

  localparam int unsigned TICK_DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned GRACE_TICKS = BELT_GRACE_S * TICK_HZ;
  localparam int unsigned MAX_TICKS   = ALERT_MAX_S * TICK_HZ;
  localparam int unsigned CNT_W       =
    cnt_width((GRACE_TICKS > MAX_TICKS) ? GRACE_TICKS : MAX_TICKS);
  localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_TICKS);
  localparam logic [CNT_W-1:0] MAX_LOAD   = CNT_W'(MAX_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic tick;

  dash_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Input register stage; belt_prev_q holds the previous belt sample for edge detect.
  logic               ign_q, mov_q, ack_q;
  logic [N_DOORS-1:0] door_q;
  logic [N_BELTS-1:0] belt_q, belt_prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ign_q       <= 1'b0;
      mov_q       <= 1'b0;
      ack_q       <= 1'b0;
      door_q      <= '0;
      belt_q      <= '0;
      belt_prev_q <= '0;
    end else begin
      ign_q       <= ignition;
      mov_q       <= moving;
      ack_q       <= ack;
      door_q      <= door_open;
      belt_q      <= belt_open;
      belt_prev_q <= belt_q;
    end
  end

  logic door_c, belt_c, belt_new;

  assign door_c   = ign_q & mov_q & (|door_q);
  assign belt_c   = ign_q & (|belt_q);
  assign belt_new = |(belt_q & ~belt_prev_q);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic               half_q, half_d;
  logic               buzzer_q, buzzer_d;
  logic [N_DOORS-1:0] door_led_q, door_led_d;
  logic [N_BELTS-1:0] belt_led_q, belt_led_d;
  alert_class_e       alert_q, alert_d;

  // Next state, counters and beep phase; outputs derive from next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    half_d  = half_q;

    case (state_q)
      IDLE: begin
        if (door_c) begin
          state_d = DOOR_ALERT;
        end else if (belt_c) begin
          state_d = BELT_GRACE;
          cnt_d   = GRACE_LOAD;
        end
      end
      BELT_GRACE: begin
        if (door_c) begin
          state_d = DOOR_ALERT;
        end else if (!belt_c) begin
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = BELT_ALERT;
            cnt_d   = MAX_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      BELT_ALERT: begin
        if (door_c) begin
          state_d = DOOR_ALERT;
        end else if (!belt_c) begin
          state_d = IDLE;
        end else if (ack_q) begin
          state_d = MUTED;
        end else if (tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = MUTED;
          end else begin
            cnt_d  = cnt_q - CNT_ONE;
            half_d = ~half_q;
            if (half_q) phase_d = ~phase_q;
          end
        end
      end
      DOOR_ALERT: begin
        if (!door_c) begin
          state_d = IDLE;
        end else if (tick) begin
          phase_d = ~phase_q;
        end
      end
      MUTED: begin
        if (door_c) begin
          state_d = DOOR_ALERT;
        end else if (!belt_c) begin
          state_d = IDLE;
        end else if (belt_new) begin
          state_d = BELT_ALERT;
          cnt_d   = MAX_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) cnt_d = '0;

    // Every fresh alert starts with the buzzer on.
    if ((state_d != state_q) && ((state_d == DOOR_ALERT) || (state_d == BELT_ALERT))) begin
      phase_d = 1'b1;
      half_d  = 1'b0;
    end

    buzzer_d   = ((state_d == DOOR_ALERT) || (state_d == BELT_ALERT)) & phase_d;
    alert_d    = (state_d == DOOR_ALERT) ? ALERT_DOOR :
                 (state_d == BELT_ALERT) ? ALERT_BELT : ALERT_NONE;
    door_led_d = ((state_d == DOOR_ALERT) && !phase_d) ? '0 : door_q;
    belt_led_d = belt_q & {N_BELTS{ign_q}};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      half_q     <= 1'b0;
      buzzer_q   <= 1'b0;
      door_led_q <= '0;
      belt_led_q <= '0;
      alert_q    <= ALERT_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      half_q     <= half_d;
      buzzer_q   <= buzzer_d;
      door_led_q <= door_led_d;
      belt_led_q <= belt_led_d;
      alert_q    <= alert_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign door_led    = door_led_q;
  assign belt_led    = belt_led_q;
  assign alert_class = alert_q;

endmodule

// File: tb/tb_dash_alert_sched.sv
// Scoreboard bench for dash_alert_sched: a tick-level behavioural model
// predicts every output cycle; a monitor compares the DUT against it.
module tb_dash_alert_sched;

  localparam int unsigned CLK_HZ  = 16;
  localparam int unsigned TICK_HZ = 4;
  localparam int unsigned GRACE_S = 2;
  localparam int unsigned MAX_S   = 3;
  localparam int unsigned ND      = 4;
  localparam int unsigned NB      = 2;
  localparam int DIV     = int'(CLK_HZ / TICK_HZ);
  localparam int GRACE_T = int'(GRACE_S * TICK_HZ);
  localparam int MAX_T   = int'(MAX_S * TICK_HZ);

  localparam int M_IDLE  = 0;
  localparam int M_GRACE = 1;
  localparam int M_BELT  = 2;
  localparam int M_DOOR  = 3;
  localparam int M_MUTED = 4;

  typedef struct packed {
    logic          buzzer;
    logic [ND-1:0] door_led;
    logic [NB-1:0] belt_led;
    logic [1:0]    cls;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          ignition, moving, ack;
  logic [ND-1:0] door_open;
  logic [NB-1:0] belt_open;
  logic          buzzer;
  logic [ND-1:0] door_led;
  logic [NB-1:0] belt_led;
  logic [1:0]    alert_class;

  dash_alert_sched #(
    .CLK_HZ       (CLK_HZ),
    .TICK_HZ      (TICK_HZ),
    .BELT_GRACE_S (GRACE_S),
    .ALERT_MAX_S  (MAX_S),
    .N_DOORS      (ND),
    .N_BELTS      (NB)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ignition    (ignition),
    .moving      (moving),
    .door_open   (door_open),
    .belt_open   (belt_open),
    .ack         (ack),
    .buzzer      (buzzer),
    .door_led    (door_led),
    .belt_led    (belt_led),
    .alert_class (alert_class)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  exp_t expq[$];

  // Inputs requested for the next cycle (ack is a self-clearing pulse).
  bit          nx_ign, nx_mov, nx_ack;
  logic [ND-1:0] nx_door;
  logic [NB-1:0] nx_belt;

  // Reference model: mode plus remaining ticks and ticks elapsed in the alert.
  int  mode, grace_left, alert_left, beep, edge_cnt;
  bit  pulse_prev;
  bit  r_ign, r_mov, r_ack;
  logic [ND-1:0] r_door;
  logic [NB-1:0] r_belt, r_belt_prev;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; grace_left = 0; alert_left = 0; beep = 0; edge_cnt = 0;
    pulse_prev = 1'b0;
    r_ign = 1'b0; r_mov = 1'b0; r_ack = 1'b0;
    r_door = '0; r_belt = '0; r_belt_prev = '0;
  endtask

  task automatic start_door();
    mode = M_DOOR; beep = 0;
  endtask

  task automatic start_belt();
    mode = M_BELT; alert_left = MAX_T; beep = 0;
  endtask

  // One clock edge of the model: act on the previously captured inputs, then capture.
  task automatic model_step();
    bit   door_c, belt_c, belt_new, tick, ph;
    exp_t e;
    edge_cnt++;
    tick     = pulse_prev;
    door_c   = r_ign && r_mov && (r_door != '0);
    belt_c   = r_ign && (r_belt != '0);
    belt_new = ((r_belt & ~r_belt_prev) != '0);
    case (mode)
      M_IDLE:  if (door_c) start_door();
               else if (belt_c) begin mode = M_GRACE; grace_left = GRACE_T; end
      M_GRACE: if (door_c) start_door();
               else if (!belt_c) mode = M_IDLE;
               else if (tick) begin
                 grace_left--;
                 if (grace_left == 0) start_belt();
               end
      M_BELT:  if (door_c) start_door();
               else if (!belt_c) mode = M_IDLE;
               else if (r_ack) mode = M_MUTED;
               else if (tick) begin
                 alert_left--;
                 if (alert_left == 0) mode = M_MUTED;
                 else beep++;
               end
      M_DOOR:  if (!door_c) mode = M_IDLE;
               else if (tick) beep++;
      default: if (door_c) start_door();
               else if (!belt_c) mode = M_IDLE;
               else if (belt_new) start_belt();
    endcase
    ph         = (mode == M_DOOR) ? (beep % 2 == 0) : ((beep / 2) % 2 == 0);
    e.buzzer   = ((mode == M_DOOR) || (mode == M_BELT)) && ph;
    e.cls      = (mode == M_DOOR) ? 2'd2 : (mode == M_BELT) ? 2'd1 : 2'd0;
    e.door_led = ((mode == M_DOOR) && !ph) ? '0 : r_door;
    e.belt_led = r_ign ? r_belt : '0;
    expq.push_back(e);
    r_belt_prev = r_belt;
    r_ign  = ignition;
    r_mov  = moving;
    r_ack  = ack;
    r_door = door_open;
    r_belt = belt_open;
    pulse_prev = ((edge_cnt % DIV) == 0);
  endtask

  task automatic apply();
    ignition  = nx_ign;
    moving    = nx_mov;
    door_open = nx_door;
    belt_open = nx_belt;
    ack       = nx_ack;
    nx_ack    = 1'b0;
    model_step();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      apply();
    end
  endtask

  // Line up ack or belt release with the final tick of a belt alert.
  task automatic hit_expiry(input bit by_ack);
    int n = 0;
    while (!(mode == M_BELT && alert_left == 1 && ((edge_cnt + 1) % DIV) == 0) && n < 400) begin
      step(1);
      n++;
    end
    if (by_ack) nx_ack = 1'b1;
    else nx_belt = '0;
    step(8);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".buzzer"}, 8'(buzzer), 8'd0);
    chk({tag, ".door_led"}, 8'(door_led), 8'd0);
    chk({tag, ".belt_led"}, 8'(belt_led), 8'd0);
    chk({tag, ".alert_class"}, 8'(alert_class), 8'd0);
  endtask

  // Monitor: the DUT drives a result every cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && expq.size() > 0) begin
        e = expq.pop_front();
        chk("buzzer", 8'(buzzer), 8'(e.buzzer));
        chk("door_led", 8'(door_led), 8'(e.door_led));
        chk("belt_led", 8'(belt_led), 8'(e.belt_led));
        chk("alert_class", 8'(alert_class), 8'(e.cls));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nx_ign = 0; nx_mov = 0; nx_ack = 0; nx_door = '0; nx_belt = '0;
    ignition = 1'b1; moving = 1'b1; ack = 1'b0; door_open = 4'hF; belt_open = 2'b11;
    model_reset();
    repeat (3) @(negedge clock);
    check_all_zero("reset");

    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    apply();

    // Belt grace, alert, then auto-mute with the LED still lit.
    nx_ign = 1; nx_belt = 2'b01;
    step(GRACE_T * DIV + MAX_T * DIV + 20);

    // A second belt opening re-arms the alert; then the driver mutes it.
    nx_belt = 2'b11; step(20);
    nx_ack = 1; step(10);
    nx_belt = 2'b01; step(3);
    nx_belt = 2'b11; step(30);

    // Door open while moving takes over and ignores ack.
    nx_mov = 1; nx_door = 4'b0100; step(10);
    nx_ack = 1; step(30);

    // Door close falls back to a full belt grace, then a door preempts the belt alert.
    nx_door = '0; step(GRACE_T * DIV + 20);
    nx_door = 4'b0001; step(12);
    nx_door = '0; step(GRACE_T * DIV + 16);

    // Ignition drop during a door alert, then reset asserted mid-alert.
    nx_door = 4'b1000; step(9);
    nx_ign = 0; step(6);
    nx_ign = 1; step(6);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    expq.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    apply();
    step(10);

    // Ack coinciding with expiry, then belt release coinciding with expiry.
    nx_door = '0; nx_mov = 0; nx_belt = 2'b01;
    hit_expiry(1'b1);
    nx_belt = '0; step(3);
    nx_belt = 2'b01;
    hit_expiry(1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) nx_ign = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) nx_mov = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) nx_door = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 24) == 0) nx_belt = 2'($urandom);
      if ($urandom_range(0, 29) == 0) nx_ack = 1'b1;
      step(1);
    end

    step(2);
    @(posedge clock);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
